// File: rtl/char_seq_ctrl.sv
// char_seq_ctrl: steps segmented character bitmaps through the template matcher
// and assembles the plate word. Optional WAIT watchdog: `define CHAR_SEQ_TIMEOUT_EN.
module char_seq_ctrl #(
    parameter int NUM_CHARS   = 7,
    parameter int MATCH_LAT   = 3,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   pixelclk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   char_valid,
    input  logic [39:0]            char_in,
    output logic                   char_ready,
    output logic [39:0]            match_char,
    input  logic [7:0]             match_result,
    output logic [IDX_W-1:0]       char_idx,
    output logic [NUM_CHARS*8-1:0] plate_out,
    output logic                   plate_valid,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int LAT_W = (MATCH_LAT > 0) ? $clog2(MATCH_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MATCH_LAT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MATCH,
        DONE
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;

`ifdef CHAR_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state       <= IDLE;
            char_ready  <= 1'b0;
            busy        <= 1'b0;
            match_char  <= '0;
            lat_cnt     <= '0;
            char_idx    <= '0;
            plate_out   <= '0;
            plate_valid <= 1'b0;
`ifdef CHAR_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            plate_valid <= 1'b0;
`ifdef CHAR_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        char_idx   <= '0;
                        plate_out  <= '0;
                        char_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= WAIT;
`ifdef CHAR_SEQ_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (char_valid && char_ready) begin
                        match_char <= char_in;
                        lat_cnt    <= '0;
                        char_ready <= 1'b0;
                        state      <= MATCH;
`ifdef CHAR_SEQ_TIMEOUT_EN
                        wd_cnt     <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        // Abandon the plate; filled slots stay visible
                        timeout_err <= 1'b1;
                        char_ready  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                MATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        for (int i = 0; i < NUM_CHARS; i++) begin
                            if (char_idx == IDX_W'(i))
                                plate_out[i*8 +: 8] <= match_result;
                        end
                        if (char_idx == IDX_LAST) begin
                            plate_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            char_idx   <= char_idx + 1'b1;
                            char_ready <= 1'b1;
                            state      <= WAIT;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    char_ready <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_seq_ctrl.sv
// tb_char_seq_ctrl: plate vectors from a table, plate words checked through a
// scoreboard, plus reset-mid-plate, sampling-point and watchdog sequences.
module tb_char_seq_ctrl;

    logic        pixelclk = 1'b0;
    logic        reset;
    logic        start;
    logic        char_valid;
    logic [39:0] char_in;
    logic        char_ready;
    logic [39:0] match_char;
    logic [7:0]  match_result;
    logic [2:0]  char_idx;
    logic [55:0] plate_out;
    logic        plate_valid;
    logic        busy;
    logic        timeout_err;

    char_seq_ctrl #(
        .NUM_CHARS  (7),
        .MATCH_LAT  (3),
        .IDX_W      (3),
        .TIMEOUT_CYC(16)
    ) dut (
        .pixelclk    (pixelclk),
        .reset       (reset),
        .start       (start),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .char_ready  (char_ready),
        .match_char  (match_char),
        .match_result(match_result),
        .char_idx    (char_idx),
        .plate_out   (plate_out),
        .plate_valid (plate_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 pixelclk = ~pixelclk;

    int cyc = 0;
    always @(posedge pixelclk) cyc <= cyc + 1;

    // Matcher model: three registered stages on the bitmap's low byte
    logic [7:0] m1 = '0, m2 = '0, m3 = '0;
    logic       use_direct = 1'b0;
    logic [7:0] direct_val = '0;
    always @(posedge pixelclk) begin
        m1 <= match_char[7:0];
        m2 <= m1;
        m3 <= m2;
    end
    assign match_result = use_direct ? direct_val : m3;

    int passed = 0;
    int total = 0;
    int pv_count = 0;
    logic [55:0] sb[$];
    logic [39:0] last_bm = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge pixelclk) begin
        if (!reset && plate_valid) begin
            pv_count++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_plate: got %h expected none",
                         plate_out);
            end else begin
                chk("plate_out", {8'h0, plate_out}, {8'h0, sb.pop_front()});
            end
        end
    end

    typedef struct {
        logic [7:0]  base;
        int          gap;
        bit          poke;
        bit          glitch;
        logic [55:0] exp;
    } vec_t;

    vec_t tbl[5];

    task automatic feed(input logic [7:0] code, input bit glitch,
                        input bit poke, input int idx, output int acc);
        logic [39:0] bm;
        int n;
        bm = {$urandom(), code};
        char_in = bm;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 64) begin
            @(negedge pixelclk);
            n++;
        end
        chk("ready_wait", {63'h0, char_ready}, 64'h1);
        @(negedge pixelclk);
        acc = cyc;
        last_bm = bm;
        for (int k = 0; k < 4; k++) begin
            chk("ready_in_match", {63'h0, char_ready}, 64'h0);
            chk("match_char_hold", {24'h0, match_char}, {24'h0, bm});
            chk("char_idx", {61'h0, char_idx}, 64'(idx));
            char_in = ~bm;
            if (glitch) begin
                use_direct = 1'b1;
                direct_val = (k == 3) ? 8'h41 : 8'hFF;
            end
            if (poke) start = (k == 1);
            @(negedge pixelclk);
        end
        use_direct = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_plate(input vec_t v);
        int acc[7];
        sb.push_back(v.exp);
        start = 1'b1;
        @(negedge pixelclk);
        start = 1'b0;
        chk("start_busy", {63'h0, busy}, 64'h1);
        chk("start_ready", {63'h0, char_ready}, 64'h1);
        chk("start_plate_clr", {8'h0, plate_out}, 64'h0);
        for (int i = 0; i < 7; i++) begin
            feed(v.base + 8'(i), v.glitch && i == 0, v.poke && i == 2,
                 i, acc[i]);
            if (i > 0)
                chk("accept_spacing", 64'(acc[i] - acc[i-1]),
                    64'(5 + v.gap));
            if (i < 6) begin
                chk("ready_in_wait", {63'h0, char_ready}, 64'h1);
                if (v.gap > 0) begin
                    char_valid = 1'b0;
                    repeat (v.gap) @(negedge pixelclk);
                    chk("ready_gap", {63'h0, char_ready}, 64'h1);
                end
            end
        end
        chk("plate_valid_hi", {63'h0, plate_valid}, 64'h1);
        chk("plate_edge", 64'(cyc - acc[0]), 64'(6 * (5 + v.gap) + 4));
        @(negedge pixelclk);
        char_valid = 1'b0;
        chk("plate_valid_lo", {63'h0, plate_valid}, 64'h0);
        chk("idle_busy", {63'h0, busy}, 64'h0);
        chk("plate_hold", {8'h0, plate_out}, {8'h0, v.exp});
        chk("match_char_idle", {24'h0, match_char}, {24'h0, last_bm});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, {63'h0, char_ready}, 64'h0);
        chk({tag, "_match_char"}, {24'h0, match_char}, 64'h0);
        chk({tag, "_idx"}, {61'h0, char_idx}, 64'h0);
        chk({tag, "_plate"}, {8'h0, plate_out}, 64'h0);
        chk({tag, "_pvalid"}, {63'h0, plate_valid}, 64'h0);
        chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
        chk({tag, "_tmo"}, {63'h0, timeout_err}, 64'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int a;
        tbl[0] = '{8'h30, 0,  1'b0, 1'b0, 56'h36353433323130};
        tbl[1] = '{8'h30, 10, 1'b0, 1'b0, 56'h36353433323130};
        tbl[2] = '{8'h41, 1,  1'b1, 1'b0, 56'h47464544434241};
        tbl[3] = '{8'hF9, 2,  1'b0, 1'b0, 56'hFFFEFDFCFBFAF9};
        tbl[4] = '{8'h30, 0,  1'b0, 1'b1, 56'h36353433323141};

        // Reset dominates start and char_valid
        reset = 1'b1;
        start = 1'b1;
        char_valid = 1'b1;
        char_in = '1;
        repeat (3) @(negedge pixelclk);
        chk_zero("reset");
        reset = 1'b0;
        start = 1'b0;
        char_valid = 1'b0;
        @(negedge pixelclk);
        chk("post_reset_busy", {63'h0, busy}, 64'h0);

        // char_valid in IDLE is ignored
        char_valid = 1'b1;
        char_in = {$urandom(), 8'hAA};
        repeat (3) begin
            @(negedge pixelclk);
            chk("idle_ready", {63'h0, char_ready}, 64'h0);
            chk("idle_no_latch", {24'h0, match_char}, 64'h0);
        end
        char_valid = 1'b0;
        @(negedge pixelclk);

        for (int t = 0; t < 5; t++) run_plate(tbl[t]);

        // Reset during MATCH of slot 3
        start = 1'b1;
        @(negedge pixelclk);
        start = 1'b0;
        feed(8'h60, 1'b0, 1'b0, 0, a);
        feed(8'h61, 1'b0, 1'b0, 1, a);
        feed(8'h62, 1'b0, 1'b0, 2, a);
        char_in = {$urandom(), 8'h63};
        @(negedge pixelclk);
        chk("slot3_in_match", {63'h0, char_ready}, 64'h0);
        @(negedge pixelclk);
        reset = 1'b1;
        @(negedge pixelclk);
        reset = 1'b0;
        char_valid = 1'b0;
        chk_zero("mid_reset");
        @(negedge pixelclk);
        chk("mid_reset_idle", {63'h0, busy}, 64'h0);
        run_plate(tbl[0]);

        // Two characters, then the segmenter goes quiet
        start = 1'b1;
        @(negedge pixelclk);
        start = 1'b0;
        feed(8'h50, 1'b0, 1'b0, 0, a);
        feed(8'h51, 1'b0, 1'b0, 1, a);
        char_valid = 1'b0;
`ifdef CHAR_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge pixelclk);
            chk("wd_pulse", {63'h0, timeout_err}, (k == 16) ? 64'h1 : 64'h0);
        end
        @(negedge pixelclk);
        chk("wd_pulse_end", {63'h0, timeout_err}, 64'h0);
        chk("wd_idle", {63'h0, busy}, 64'h0);
        chk("wd_slots", {8'h0, plate_out}, 64'h5150);
`else
        repeat (40) @(negedge pixelclk);
        chk("no_wd_busy", {63'h0, busy}, 64'h1);
        chk("no_wd_ready", {63'h0, char_ready}, 64'h1);
        chk("no_wd_tmo", {63'h0, timeout_err}, 64'h0);
        chk("no_wd_slots", {8'h0, plate_out}, 64'h5150);
`endif
        reset = 1'b1;
        @(negedge pixelclk);
        reset = 1'b0;
        chk_zero("final_reset");

        chk("plate_count", 64'(pv_count), 64'd6);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
